// File: rtl/jtframe_dwnld_pack_if.sv
// Bus bundle between the ioctl loader, the download packer and the SDRAM
// write port. The loader/memory side uses "master", the packer uses "slave".
interface jtframe_dwnld_pack_if #(
  parameter int AW = 22
);
  logic          downloading;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wr;
  logic          ioctl_wait;
  logic          header;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_ba;
  logic          prog_we;
  logic          sdram_ack;
  logic          prom_we;
  logic [24:0]   prom_addr;
  logic [7:0]    prom_data;
  logic          busy;
  logic [15:0]   cksum;

  modport master (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    input  ioctl_wait, header, prog_addr, prog_data, prog_mask, prog_ba,
           prog_we, prom_we, prom_addr, prom_data, busy, cksum
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    output ioctl_wait, header, prog_addr, prog_data, prog_mask, prog_ba,
           prog_we, prom_we, prom_addr, prom_data, busy, cksum
  );
endinterface

// File: rtl/jtframe_dwnld_pack.sv
// ROM download packer: turns the ioctl byte stream into 16-bit SDRAM writes,
// pairing bytes of the same word, queuing words in a small FIFO so the loader
// is decoupled from sdram_ack, and sending PROM bytes out as single pulses.
// Optional feature macro: JTFRAME_DWNLD_CKSUM_EN enables the running byte sum
// on cksum; without it cksum is tied to zero.
module jtframe_dwnld_pack #(
  parameter int          AW         = 22,
  parameter int          HEADER     = 0,
  parameter logic [24:0] PROM_START = ~25'd0,
  parameter logic [24:0] BA1_START  = ~25'd0,
  parameter logic [24:0] BA2_START  = ~25'd0,
  parameter logic [24:0] BA3_START  = ~25'd0,
  parameter bit          SWAB       = 1'b0,
  parameter int          FIFO_DW    = 2
)(
  input logic                 clk,
  input logic                 rst_n,
  jtframe_dwnld_pack_if.slave bus
);

  localparam int            DEPTH    = 2**FIFO_DW;
  localparam int            CW       = FIFO_DW + 1;
  localparam logic [24:0]   NONE     = ~25'd0;
  localparam logic [24:0]   HDR      = 25'(HEADER);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  typedef struct packed {
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } entry_t;

  logic [24:0]        part_addr, base, eff;
  logic [1:0]         bank;
  logic [AW-1:0]      word;
  logic               lane, header_c, accepted, prom_sel, acc_prom, acc_sdram;
  logic               dl_q, rise, flush;
  logic               pend_valid, pend_lane, pend_live;
  logic [1:0]         pend_ba;
  logic [AW-1:0]      pend_word;
  logic [7:0]         pend_byte;
  logic               push, push_ok, pend_load, pend_clear, pop, empty, full;
  entry_t             push_entry, partial, head;
  entry_t             mem [DEPTH];
  logic [FIFO_DW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt, cnt_next;
  logic               wait_q, prom_we_q;
  logic [24:0]        prom_addr_q;
  logic [7:0]         prom_data_q;
  logic               unused_eff;

  // Address decode: strip header, pick the highest bank whose start is reached
  always_comb begin
    part_addr = bus.ioctl_addr - HDR;
    header_c  = (HEADER != 0) && (bus.ioctl_addr < HDR) && bus.downloading;
    bank      = 2'd0;
    base      = 25'd0;
    if (BA3_START != NONE && part_addr >= BA3_START) begin
      bank = 2'd3;
      base = BA3_START;
    end else if (BA2_START != NONE && part_addr >= BA2_START) begin
      bank = 2'd2;
      base = BA2_START;
    end else if (BA1_START != NONE && part_addr >= BA1_START) begin
      bank = 2'd1;
      base = BA1_START;
    end
    eff       = part_addr - base;
    word      = eff[AW:1];
    lane      = eff[0] ^ SWAB;
    accepted  = bus.ioctl_wr & bus.downloading & ~header_c;
    prom_sel  = (PROM_START != NONE) && (part_addr >= PROM_START);
    acc_prom  = accepted & prom_sel;
    acc_sdram = accepted & ~prom_sel;
  end

  assign unused_eff = ^eff;

  assign rise      = bus.downloading & ~dl_q;
  assign flush     = dl_q & ~bus.downloading & pend_valid;
  assign pend_live = pend_valid & ~rise;

  // Pair the incoming byte with the pending one, or push the pending byte alone
  always_comb begin
    partial.ba   = pend_ba;
    partial.addr = pend_word;
    partial.data = pend_lane ? {pend_byte, 8'h00} : {8'h00, pend_byte};
    partial.mask = pend_lane ? 2'b01 : 2'b10;
    push         = 1'b0;
    push_entry   = partial;
    pend_load    = 1'b0;
    pend_clear   = 1'b0;
    if (flush) begin
      push       = 1'b1;
      pend_clear = 1'b1;
    end else if (acc_sdram) begin
      if (pend_live && pend_ba == bank && pend_word == word && pend_lane != lane) begin
        push            = 1'b1;
        push_entry.data = lane ? {bus.ioctl_dout, pend_byte} : {pend_byte, bus.ioctl_dout};
        push_entry.mask = 2'b00;
        pend_clear      = 1'b1;
      end else begin
        push      = pend_live;
        pend_load = 1'b1;
      end
    end else if (rise) begin
      pend_clear = 1'b1;
    end
  end

  // Download edge detector and the pending half-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_ba    <= 2'd0;
      pend_word  <= '0;
      pend_lane  <= 1'b0;
      pend_byte  <= 8'd0;
    end else begin
      dl_q <= bus.downloading;
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_ba    <= bank;
        pend_word  <= word;
        pend_lane  <= lane;
        pend_byte  <= bus.ioctl_dout;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_LVL);
  assign pop     = bus.sdram_ack & ~empty;
  assign push_ok = push & (~full | pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    cnt_next = cnt;
    if (push_ok && !pop) cnt_next = cnt + 1'b1;
    else if (!push_ok && pop) cnt_next = cnt - 1'b1;
  end

  // FIFO storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, count and the registered loader back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      wait_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt    <= cnt_next;
      wait_q <= (cnt_next >= WAIT_LVL);
    end
  end

  // PROM bytes skip the FIFO and leave as a one-cycle strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prom_we_q   <= 1'b0;
      prom_addr_q <= 25'd0;
      prom_data_q <= 8'd0;
    end else begin
      prom_we_q <= acc_prom;
      if (acc_prom) begin
        prom_addr_q <= part_addr;
        prom_data_q <= bus.ioctl_dout;
      end
    end
  end

`ifdef JTFRAME_DWNLD_CKSUM_EN
  logic [15:0] cksum_q;

  // Running byte sum, restarted when a new download begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= 16'd0;
    end else if (rise) begin
      cksum_q <= accepted ? {8'd0, bus.ioctl_dout} : 16'd0;
    end else if (accepted) begin
      cksum_q <= cksum_q + {8'd0, bus.ioctl_dout};
    end
  end

  assign bus.cksum = cksum_q;
`else
  assign bus.cksum = 16'd0;
`endif

  assign head           = mem[rd_ptr];
  assign bus.prog_we    = ~empty;
  assign bus.prog_ba    = empty ? 2'd0  : head.ba;
  assign bus.prog_addr  = empty ? '0    : head.addr;
  assign bus.prog_data  = empty ? 16'd0 : head.data;
  assign bus.prog_mask  = empty ? 2'd0  : head.mask;
  assign bus.ioctl_wait = wait_q;
  assign bus.header     = header_c;
  assign bus.prom_we    = prom_we_q;
  assign bus.prom_addr  = prom_addr_q;
  assign bus.prom_data  = prom_data_q;
  assign bus.busy       = pend_valid | ~empty | flush;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Bench for jtframe_dwnld_pack: two instances (banked/PROM layout with no
// header, and a swapped-lane layout with a two-byte header) driven with
// directed bytes and checked against hand-computed SDRAM/PROM writes.
module tb_jtframe_dwnld_pack;

`ifdef JTFRAME_DWNLD_CKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  bit   release_ack;
  int   drained;

  jtframe_dwnld_pack_if #(.AW(22)) ia ();
  jtframe_dwnld_pack_if #(.AW(22)) ib ();

  jtframe_dwnld_pack #(
    .AW(22), .HEADER(0), .PROM_START(25'h200), .BA1_START(25'h100),
    .SWAB(1'b0), .FIFO_DW(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  jtframe_dwnld_pack #(
    .AW(22), .HEADER(2), .SWAB(1'b1), .FIFO_DW(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  typedef struct packed {
    logic [24:0] a0;
    logic [7:0]  d0;
    logic [24:0] a1;
    logic [7:0]  d1;
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Send one loader byte to instance a (sel=0) or b (sel=1), honouring ioctl_wait
  task automatic apply_stimulus(input bit sel, input logic [24:0] addr, input logic [7:0] data);
    int guard = 0;
    while ((sel ? ib.ioctl_wait : ia.ioctl_wait) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_output("ioctl_wait_timeout", 32'(guard), 32'd0);
    if (sel) begin
      ib.ioctl_addr = addr;
      ib.ioctl_dout = data;
      ib.ioctl_wr   = 1'b1;
    end else begin
      ia.ioctl_addr = addr;
      ia.ioctl_dout = data;
      ia.ioctl_wr   = 1'b1;
    end
    @(negedge clk);
    ia.ioctl_wr = 1'b0;
    ib.ioctl_wr = 1'b0;
  endtask

  task automatic ack_pulse(input bit sel);
    if (sel) ib.sdram_ack = 1'b1;
    else     ia.sdram_ack = 1'b1;
    @(negedge clk);
    ia.sdram_ack = 1'b0;
    ib.sdram_ack = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    release_ack = 1'b0;
    drained     = 0;
    rst_n       = 1'b0;
    ia.downloading = 1'b0; ia.ioctl_addr = '0; ia.ioctl_dout = '0;
    ia.ioctl_wr    = 1'b0; ia.sdram_ack  = 1'b0;
    ib.downloading = 1'b0; ib.ioctl_addr = '0; ib.ioctl_dout = '0;
    ib.ioctl_wr    = 1'b0; ib.sdram_ack  = 1'b0;

    //          a0        d0     a1        d1     ba    addr      data       mask
    vecs[0] = {25'h000, 8'h11, 25'h001, 8'h22, 2'd0, 22'h000, 16'h2211, 2'b00};
    vecs[1] = {25'h001, 8'h22, 25'h000, 8'h11, 2'd0, 22'h000, 16'h2211, 2'b00};
    vecs[2] = {25'h0FE, 8'hA5, 25'h0FF, 8'h5A, 2'd0, 22'h07F, 16'h5AA5, 2'b00};
    vecs[3] = {25'h100, 8'h01, 25'h101, 8'h02, 2'd1, 22'h000, 16'h0201, 2'b00};
    vecs[4] = {25'h102, 8'hC3, 25'h103, 8'h3C, 2'd1, 22'h001, 16'h3CC3, 2'b00};
    vecs[5] = {25'h1FE, 8'h77, 25'h1FF, 8'h88, 2'd1, 22'h07F, 16'h8877, 2'b00};

    repeat (3) @(negedge clk);
    check_output("rst_prog_we",   32'(ia.prog_we),    32'd0);
    check_output("rst_busy",      32'(ia.busy),       32'd0);
    check_output("rst_wait",      32'(ia.ioctl_wait), 32'd0);
    check_output("rst_prom_we",   32'(ia.prom_we),    32'd0);
    check_output("rst_prog_data", 32'(ia.prog_data),  32'd0);
    check_output("rst_cksum",     32'(ia.cksum),      32'd0);
    rst_n = 1'b1;
    ia.downloading = 1'b1;
    @(negedge clk);

    // Basic pair, write request held while ack stays low
    apply_stimulus(0, 25'h000, 8'h11);
    check_output("pair_no_early_we", 32'(ia.prog_we), 32'd0);
    apply_stimulus(0, 25'h001, 8'h22);
    repeat (3) @(negedge clk);
    check_output("pair_we_held", 32'(ia.prog_we),   32'd1);
    check_output("pair_data",    32'(ia.prog_data), 32'h2211);
    check_output("pair_mask",    32'(ia.prog_mask), 32'd0);
    ack_pulse(0);
    check_output("pair_we_after_ack", 32'(ia.prog_we), 32'd0);

    // Table of full-word pairs across banks and byte orders
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, vecs[i].a0, vecs[i].d0);
      apply_stimulus(0, vecs[i].a1, vecs[i].d1);
      check_output($sformatf("vec%0d_we",   i), 32'(ia.prog_we),   32'd1);
      check_output($sformatf("vec%0d_ba",   i), 32'(ia.prog_ba),   32'(vecs[i].ba));
      check_output($sformatf("vec%0d_addr", i), 32'(ia.prog_addr), 32'(vecs[i].addr));
      check_output($sformatf("vec%0d_data", i), 32'(ia.prog_data), 32'(vecs[i].data));
      check_output($sformatf("vec%0d_mask", i), 32'(ia.prog_mask), 32'(vecs[i].mask));
      ack_pulse(0);
      check_output($sformatf("vec%0d_drained", i), 32'(ia.prog_we), 32'd0);
    end

    // PROM byte bypasses the FIFO
    apply_stimulus(0, 25'h205, 8'h5A);
    check_output("prom_we",      32'(ia.prom_we),   32'd1);
    check_output("prom_addr",    32'(ia.prom_addr), 32'h205);
    check_output("prom_data",    32'(ia.prom_data), 32'h5A);
    check_output("prom_no_prog", 32'(ia.prog_we),   32'd0);
    check_output("prom_no_busy", 32'(ia.busy),      32'd0);
    @(negedge clk);
    check_output("prom_we_one_cycle", 32'(ia.prom_we), 32'd0);

    // Word change pushes a partial, falling download flushes the last byte
    apply_stimulus(0, 25'h010, 8'h11);
    apply_stimulus(0, 25'h005, 8'hAB);
    check_output("part_we",   32'(ia.prog_we),   32'd1);
    check_output("part_addr", 32'(ia.prog_addr), 32'h8);
    check_output("part_data", 32'(ia.prog_data), 32'h0011);
    check_output("part_mask", 32'(ia.prog_mask), 32'b10);
    ack_pulse(0);
    check_output("pend_busy", 32'(ia.busy),    32'd1);
    check_output("pend_no_we", 32'(ia.prog_we), 32'd0);
    ia.downloading = 1'b0;
    @(negedge clk);
    check_output("flush_we",   32'(ia.prog_we),   32'd1);
    check_output("flush_addr", 32'(ia.prog_addr), 32'h2);
    check_output("flush_data", 32'(ia.prog_data), 32'hAB00);
    check_output("flush_mask", 32'(ia.prog_mask), 32'b01);
    ack_pulse(0);
    check_output("flush_idle", 32'(ia.busy), 32'd0);

    // Back-pressure: ack held low fills the FIFO, then drain in order
    ia.downloading = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          apply_stimulus(0, 25'h040 + 25'(i), 8'h30 + 8'(i));
          if (i == 3) check_output("bp_wait_low_2", 32'(ia.ioctl_wait), 32'd0);
          if (i == 5) begin
            check_output("bp_wait_high_3", 32'(ia.ioctl_wait), 32'd1);
            check_output("bp_we_held", 32'(ia.prog_we), 32'd1);
            release_ack = 1'b1;
          end
        end
      end
      begin
        int budget = 0;
        while (drained < 8 && budget < 600) begin
          @(negedge clk);
          budget++;
          if (release_ack && ia.prog_we) begin
            check_output($sformatf("bp%0d_addr", drained), 32'(ia.prog_addr), 32'h20 + 32'(drained));
            check_output($sformatf("bp%0d_data", drained), 32'(ia.prog_data),
                         {16'd0, 8'h31 + 8'(2 * drained), 8'h30 + 8'(2 * drained)});
            check_output($sformatf("bp%0d_mask", drained), 32'(ia.prog_mask), 32'd0);
            drained++;
            ia.sdram_ack = 1'b1;
          end else begin
            ia.sdram_ack = 1'b0;
          end
        end
      end
    join
    @(negedge clk);
    ia.sdram_ack = 1'b0;
    check_output("bp_drain_count", 32'(drained),    32'd8);
    check_output("bp_busy_low",    32'(ia.busy),    32'd0);
    check_output("bp_we_low",      32'(ia.prog_we), 32'd0);
    ia.downloading = 1'b0;

    // Header skipping, swapped lanes and checksum on instance b
    ib.downloading = 1'b1;
    @(negedge clk);
    apply_stimulus(1, 25'd0, 8'h01);
    apply_stimulus(1, 25'd1, 8'h02);
    check_output("hdr_flag",    32'(ib.header), 32'd1);
    check_output("hdr_no_busy", 32'(ib.busy),   32'd0);
    apply_stimulus(1, 25'd2, 8'h03);
    check_output("hdr_flag_off", 32'(ib.header), 32'd0);
    check_output("hdr_pend",     32'(ib.busy),   32'd1);
    apply_stimulus(1, 25'd3, 8'h04);
    check_output("swab_hdr_we",   32'(ib.prog_we),   32'd1);
    check_output("swab_hdr_addr", 32'(ib.prog_addr), 32'd0);
    check_output("swab_hdr_data", 32'(ib.prog_data), 32'h0304);
    check_output("cksum_hdr",     32'(ib.cksum),     CKSUM_ON ? 32'h0007 : 32'h0);
    ack_pulse(1);
    apply_stimulus(1, 25'd4, 8'h11);
    apply_stimulus(1, 25'd5, 8'h22);
    check_output("swab_addr",  32'(ib.prog_addr), 32'd1);
    check_output("swab_data",  32'(ib.prog_data), 32'h1122);
    check_output("swab_mask",  32'(ib.prog_mask), 32'd0);
    check_output("cksum_more", 32'(ib.cksum),     CKSUM_ON ? 32'h003A : 32'h0);
    ack_pulse(1);

    // Reset in the middle of a download drops everything at once
    apply_stimulus(1, 25'd6, 8'h55);
    apply_stimulus(1, 25'd8, 8'h66);
    check_output("mid_we",   32'(ib.prog_we),   32'd1);
    check_output("mid_data", 32'(ib.prog_data), 32'h5500);
    check_output("mid_mask", 32'(ib.prog_mask), 32'b01);
    rst_n = 1'b0;
    ib.downloading = 1'b0;
    #1;
    check_output("rst_mid_we",    32'(ib.prog_we),   32'd0);
    check_output("rst_mid_busy",  32'(ib.busy),      32'd0);
    check_output("rst_mid_cksum", 32'(ib.cksum),     32'd0);
    check_output("rst_mid_data",  32'(ib.prog_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_no_flush_we",   32'(ib.prog_we), 32'd0);
    check_output("rst_no_flush_busy", 32'(ib.busy),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
